bp_cfg_sequencer: RTL and testbench
===================================

BP_CFG_SEQUENCER -- requirements
Module: bp_cfg_sequencer

Interface
REQ-001 Parameter num_core_p, default 2: number of core tiles to configure (1..64).
REQ-002 Parameter cfg_addr_width_p, default 16: config register address width.
REQ-003 Parameter cfg_data_width_p, default 32: config write data width.
REQ-004 Parameter timeout_p, default 256: maximum cycles to wait for an ack (at least 2).
REQ-005 Port clk_i, input, 1: single clock.
REQ-006 Port reset_i, input, 1: reset, asynchronous and active-high.
REQ-007 Port start_i, input, 1: start pulse that begins the configuration sequence.
REQ-008 Port icache_mode_i, input, 2: icache mode value written to every core.
REQ-009 Port dcache_mode_i, input, 2: dcache mode value written to every core.
REQ-010 Port cce_mode_i, input, 1: CCE mode value written to every core.
REQ-011 Port cfg_v_o, output, 1: config write valid.
REQ-012 Port cfg_ready_i, input, 1: target accepts the write when cfg_v_o and cfg_ready_i are both high.
REQ-013 Port cfg_core_id_o, output, clog2(num_core_p): destination core.
REQ-014 Port cfg_addr_o, output, cfg_addr_width_p: register address.
REQ-015 Port cfg_data_o, output, cfg_data_width_p: write data, zero-extended.
REQ-016 Port cfg_ack_i, input, 1: single-cycle write-complete pulse from the target.
REQ-017 Ports busy_o, done_o and err_o, outputs, 1 each: status.

Function
REQ-018 The state machine SHALL have the states IDLE, SEND, WAIT, DONE and ERROR, plus a phase bit (SETUP or RELEASE).
REQ-019 SETUP phase: for each core c = 0..num_core_p-1, in order, the block SHALL issue five writes: freeze=1, core_id=c, icache_mode, dcache_mode, cce_mode.
REQ-020 RELEASE phase: for cores 0..num_core_p-1, in order, the block SHALL issue freeze=0.
REQ-021 One full sequence SHALL therefore issue exactly 6*num_core_p writes.
REQ-022 When start_i is high in IDLE or DONE, the block SHALL clear done_o, set phase=SETUP, core=0, step=0, and go to SEND; cfg_v_o SHALL rise the next cycle.
REQ-023 The block SHALL ignore start_i in SEND, WAIT and ERROR.
REQ-024 In SEND, cfg_v_o=1, and cfg_core_id_o, cfg_addr_o and cfg_data_o SHALL stay stable until accepted; on acceptance the block SHALL go to WAIT and clear the timeout counter.
REQ-025 In WAIT, cfg_v_o=0; on cfg_ack_i the block SHALL advance step/core/phase and go to SEND, or to DONE after the final write; no idle cycle is allowed between an ack and the next cfg_v_o.
REQ-026 The block SHALL ignore cfg_ack_i outside WAIT, including an ack in the same cycle as acceptance.
REQ-027 Step wrap: after step 4, step SHALL return to 0 and core SHALL increment; after core num_core_p-1 in SETUP, phase SHALL become RELEASE with core=0.
REQ-028 Timeout: the counter SHALL increment on every WAIT cycle without an ack; when it reaches timeout_p-1 with no ack, the block SHALL enter ERROR.
REQ-029 An ack in the same cycle the counter reaches timeout_p-1 SHALL win, and no error is raised.
REQ-030 ERROR SHALL be sticky: err_o=1, cfg_v_o=0; only reset_i exits it.
REQ-031 busy_o SHALL be 1 in SEND and WAIT only; done_o SHALL be 1 in DONE only.
REQ-032 The mode inputs SHALL be sampled when each write enters SEND.

Reset
REQ-033 Asserting reset_i SHALL force IDLE immediately, including mid-sequence: cfg_v_o=0, busy_o=0, done_o=0, err_o=0, all counters=0, phase=SETUP, and cfg_core_id_o, cfg_addr_o and cfg_data_o=0.
REQ-034 After reset the block SHALL not resume a partial sequence; a new start_i is required.

Structure
REQ-035 The shared package (bp_common) SHALL hold the config address constants (freeze=0x0000, core_id=0x0001, icache_mode=0x0002, dcache_mode=0x0003, cce_mode=0x0004) and the state enum bp_cfg_seq_state_e.
REQ-036 The sub-module bp_cfg_seq_step_rom SHALL be a combinational map from (phase, step, core, modes) to (addr, data); all sequential logic SHALL remain in the top module.

Verification
REQ-037 With num_core_p=2, ready tied high and ack one cycle after acceptance, a start_i pulse -> 12 writes in the order of REQ-019/020, and done_o rises one cycle after the 12th ack.
REQ-038 Hold cfg_ready_i low for 5 cycles during write 3 -> cfg_v_o and payload stay stable for those cycles, and exactly one acceptance occurs.
REQ-039 Withhold the ack after write 2 with timeout_p=8 -> err_o=1 exactly 7 WAIT cycles after acceptance; later start_i and cfg_ack_i have no effect.
REQ-040 Assert reset_i asynchronously mid-WAIT on write 7 -> all outputs 0 within the same cycle; a new start_i restarts from core 0, step 0.
REQ-041 Pulse start_i during busy, and pulse cfg_ack_i during SEND -> both ignored, and the write count stays 12.
REQ-042 With num_core_p=1, modes icache=2, dcache=1, cce=1 -> write data 1, 0, 2, 1, 1, 0 in sequence.

Source files
------------

// File: rtl/bp_common.sv
// Shared definitions for the configuration sequencer: register map and state/phase encodings.
package bp_common;

    localparam logic [15:0] cfg_addr_freeze_gp      = 16'h0000;
    localparam logic [15:0] cfg_addr_core_id_gp     = 16'h0001;
    localparam logic [15:0] cfg_addr_icache_mode_gp = 16'h0002;
    localparam logic [15:0] cfg_addr_dcache_mode_gp = 16'h0003;
    localparam logic [15:0] cfg_addr_cce_mode_gp    = 16'h0004;

    localparam logic [2:0] cfg_last_step_gp = 3'd4;

    typedef enum logic [2:0] {
        e_cfg_seq_idle  = 3'd0,
        e_cfg_seq_send  = 3'd1,
        e_cfg_seq_wait  = 3'd2,
        e_cfg_seq_done  = 3'd3,
        e_cfg_seq_error = 3'd4
    } bp_cfg_seq_state_e;

    typedef enum logic {
        e_cfg_phase_setup   = 1'b0,
        e_cfg_phase_release = 1'b1
    } bp_cfg_phase_e;

endpackage

// File: rtl/bp_cfg_seq_step_rom.sv
// Combinational map from sequence position (phase, step, core) and mode inputs
// to the config register address and zero-extended write data.
module bp_cfg_seq_step_rom
    import bp_common::*;
#(
    parameter int core_id_width_p  = 1,
    parameter int cfg_addr_width_p = 16,
    parameter int cfg_data_width_p = 32
) (
    input  logic                        phase_i,
    input  logic [2:0]                  step_i,
    input  logic [core_id_width_p-1:0]  core_i,
    input  logic [1:0]                  icache_mode_i,
    input  logic [1:0]                  dcache_mode_i,
    input  logic                        cce_mode_i,
    output logic [cfg_addr_width_p-1:0] addr_o,
    output logic [cfg_data_width_p-1:0] data_o
);

    always_comb begin
        addr_o = '0;
        data_o = '0;
        if (phase_i == e_cfg_phase_release) begin
            addr_o = cfg_addr_width_p'(cfg_addr_freeze_gp);
        end else begin
            case (step_i)
                3'd0: begin
                    addr_o = cfg_addr_width_p'(cfg_addr_freeze_gp);
                    data_o = cfg_data_width_p'(1'b1);
                end
                3'd1: begin
                    addr_o = cfg_addr_width_p'(cfg_addr_core_id_gp);
                    data_o = cfg_data_width_p'(core_i);
                end
                3'd2: begin
                    addr_o = cfg_addr_width_p'(cfg_addr_icache_mode_gp);
                    data_o = cfg_data_width_p'(icache_mode_i);
                end
                3'd3: begin
                    addr_o = cfg_addr_width_p'(cfg_addr_dcache_mode_gp);
                    data_o = cfg_data_width_p'(dcache_mode_i);
                end
                3'd4: begin
                    addr_o = cfg_addr_width_p'(cfg_addr_cce_mode_gp);
                    data_o = cfg_data_width_p'(cce_mode_i);
                end
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/bp_cfg_sequencer.sv
// Boot-time configuration sequencer: freezes and programs every core (id, cache
// and CCE modes), then releases the cores in order, with an ack timeout.
module bp_cfg_sequencer
    import bp_common::*;
#(
    parameter int num_core_p       = 2,
    parameter int cfg_addr_width_p = 16,
    parameter int cfg_data_width_p = 32,
    parameter int timeout_p        = 256
) (
    input  logic                                                  clk_i,
    input  logic                                                  reset_i,
    input  logic                                                  start_i,
    input  logic [1:0]                                            icache_mode_i,
    input  logic [1:0]                                            dcache_mode_i,
    input  logic                                                  cce_mode_i,
    output logic                                                  cfg_v_o,
    input  logic                                                  cfg_ready_i,
    output logic [((num_core_p > 1) ? $clog2(num_core_p) : 1)-1:0] cfg_core_id_o,
    output logic [cfg_addr_width_p-1:0]                           cfg_addr_o,
    output logic [cfg_data_width_p-1:0]                           cfg_data_o,
    input  logic                                                  cfg_ack_i,
    output logic                                                  busy_o,
    output logic                                                  done_o,
    output logic                                                  err_o
);

    localparam int core_id_width_lp = (num_core_p > 1) ? $clog2(num_core_p) : 1;
    localparam int tcnt_width_lp    = $clog2(timeout_p);

    bp_cfg_seq_state_e             state_r;
    bp_cfg_phase_e                 phase_r;
    logic [2:0]                    step_r;
    logic [core_id_width_lp-1:0]   core_r;
    logic [tcnt_width_lp-1:0]      tcnt_r;
    logic [core_id_width_lp-1:0]   core_id_r;
    logic [cfg_addr_width_p-1:0]   addr_r;
    logic [cfg_data_width_p-1:0]   data_r;

    bp_cfg_phase_e                 next_phase, ld_phase;
    logic [2:0]                    next_step, ld_step;
    logic [core_id_width_lp-1:0]   next_core, ld_core;
    logic                          last_core, last_write;
    logic [cfg_addr_width_p-1:0]   rom_addr;
    logic [cfg_data_width_p-1:0]   rom_data;

    // Position of the write that follows the current one; a start overrides it
    // with the first write so the ROM always sees the write about to enter SEND.
    always_comb begin
        last_core  = (core_r == core_id_width_lp'(num_core_p - 1));
        next_phase = phase_r;
        next_step  = step_r;
        next_core  = core_r;
        if (phase_r == e_cfg_phase_setup) begin
            if (step_r == cfg_last_step_gp) begin
                next_step = '0;
                if (last_core) begin
                    next_phase = e_cfg_phase_release;
                    next_core  = '0;
                end else begin
                    next_core = core_r + core_id_width_lp'(1);
                end
            end else begin
                next_step = step_r + 3'd1;
            end
        end else begin
            next_core = core_r + core_id_width_lp'(1);
        end
        last_write = (phase_r == e_cfg_phase_release) && last_core;

        if ((state_r == e_cfg_seq_idle) || (state_r == e_cfg_seq_done)) begin
            ld_phase = e_cfg_phase_setup;
            ld_step  = '0;
            ld_core  = '0;
        end else begin
            ld_phase = next_phase;
            ld_step  = next_step;
            ld_core  = next_core;
        end
    end

    bp_cfg_seq_step_rom #(
        .core_id_width_p  (core_id_width_lp),
        .cfg_addr_width_p (cfg_addr_width_p),
        .cfg_data_width_p (cfg_data_width_p)
    ) step_rom (
        .phase_i       (ld_phase),
        .step_i        (ld_step),
        .core_i        (ld_core),
        .icache_mode_i (icache_mode_i),
        .dcache_mode_i (dcache_mode_i),
        .cce_mode_i    (cce_mode_i),
        .addr_o        (rom_addr),
        .data_o        (rom_data)
    );

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_r   <= e_cfg_seq_idle;
            phase_r   <= e_cfg_phase_setup;
            step_r    <= '0;
            core_r    <= '0;
            tcnt_r    <= '0;
            core_id_r <= '0;
            addr_r    <= '0;
            data_r    <= '0;
        end else begin
            case (state_r)
                e_cfg_seq_idle, e_cfg_seq_done: begin
                    if (start_i) begin
                        state_r   <= e_cfg_seq_send;
                        phase_r   <= ld_phase;
                        step_r    <= ld_step;
                        core_r    <= ld_core;
                        tcnt_r    <= '0;
                        core_id_r <= ld_core;
                        addr_r    <= rom_addr;
                        data_r    <= rom_data;
                    end
                end
                e_cfg_seq_send: begin
                    if (cfg_ready_i) begin
                        state_r <= e_cfg_seq_wait;
                        tcnt_r  <= '0;
                    end
                end
                e_cfg_seq_wait: begin
                    // Ack is checked first so it wins over a timeout in the same cycle.
                    if (cfg_ack_i) begin
                        if (last_write) begin
                            state_r <= e_cfg_seq_done;
                        end else begin
                            state_r   <= e_cfg_seq_send;
                            phase_r   <= ld_phase;
                            step_r    <= ld_step;
                            core_r    <= ld_core;
                            core_id_r <= ld_core;
                            addr_r    <= rom_addr;
                            data_r    <= rom_data;
                        end
                    end else begin
                        tcnt_r <= tcnt_r + tcnt_width_lp'(1);
                        if (tcnt_r == tcnt_width_lp'(timeout_p - 2)) begin
                            state_r <= e_cfg_seq_error;
                        end
                    end
                end
                e_cfg_seq_error: state_r <= e_cfg_seq_error;
                default:         state_r <= e_cfg_seq_idle;
            endcase
        end
    end

    assign cfg_v_o       = (state_r == e_cfg_seq_send);
    assign busy_o        = (state_r == e_cfg_seq_send) || (state_r == e_cfg_seq_wait);
    assign done_o        = (state_r == e_cfg_seq_done);
    assign err_o         = (state_r == e_cfg_seq_error);
    assign cfg_core_id_o = core_id_r;
    assign cfg_addr_o    = addr_r;
    assign cfg_data_o    = data_r;

endmodule

// File: tb/tb_bp_cfg_sequencer.sv
// Self-checking bench for bp_cfg_sequencer: table vectors on a single-core
// instance, randomized handshakes on a two-core instance against a write-list model.
module tb_bp_cfg_sequencer;

    localparam int num_core_lp = 2;
    localparam int timeout_lp  = 8;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    logic        a_start, a_cce, a_v, a_ready, a_ack, a_busy, a_done, a_err;
    logic [1:0]  a_ic, a_dc;
    logic [0:0]  a_core;
    logic [15:0] a_addr;
    logic [31:0] a_data;

    logic        b_start, b_cce, b_v, b_ready, b_ack, b_busy, b_done, b_err;
    logic [1:0]  b_ic, b_dc;
    logic [0:0]  b_core;
    logic [15:0] b_addr;
    logic [31:0] b_data;

    bp_cfg_sequencer #(
        .num_core_p       (num_core_lp),
        .cfg_addr_width_p (16),
        .cfg_data_width_p (32),
        .timeout_p        (timeout_lp)
    ) dut_a (
        .clk_i (clk), .reset_i (reset), .start_i (a_start),
        .icache_mode_i (a_ic), .dcache_mode_i (a_dc), .cce_mode_i (a_cce),
        .cfg_v_o (a_v), .cfg_ready_i (a_ready), .cfg_core_id_o (a_core),
        .cfg_addr_o (a_addr), .cfg_data_o (a_data), .cfg_ack_i (a_ack),
        .busy_o (a_busy), .done_o (a_done), .err_o (a_err)
    );

    bp_cfg_sequencer #(
        .num_core_p       (1),
        .cfg_addr_width_p (16),
        .cfg_data_width_p (32),
        .timeout_p        (timeout_lp)
    ) dut_b (
        .clk_i (clk), .reset_i (reset), .start_i (b_start),
        .icache_mode_i (b_ic), .dcache_mode_i (b_dc), .cce_mode_i (b_cce),
        .cfg_v_o (b_v), .cfg_ready_i (b_ready), .cfg_core_id_o (b_core),
        .cfg_addr_o (b_addr), .cfg_data_o (b_data), .cfg_ack_i (b_ack),
        .busy_o (b_busy), .done_o (b_done), .err_o (b_err)
    );

    int errors = 0;
    int checks = 0;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    typedef struct {
        int core;
        int addr;
        int data;
    } wr_t;

    wr_t exp_q[$];

    // Expected write list: five setup writes per core, then one release per core.
    function automatic void build_model(input int n, input int ic, input int dc, input int cce);
        exp_q.delete();
        for (int c = 0; c < n; c++) begin
            exp_q.push_back('{c, 0, 1});
            exp_q.push_back('{c, 1, c});
            exp_q.push_back('{c, 2, ic});
            exp_q.push_back('{c, 3, dc});
            exp_q.push_back('{c, 4, cce});
        end
        for (int c = 0; c < n; c++) exp_q.push_back('{c, 0, 0});
    endfunction

    function automatic logic [63:0] pack_a();
        return {16'(a_core), a_addr, a_data};
    endfunction

    function automatic logic [63:0] pack_exp(input wr_t e);
        return {16'(e.core), 16'(e.addr), 32'(e.data)};
    endfunction

    task automatic run_a(input int ready_pct, input int ack_min, input int ack_max, input bit noise);
        int total, accepted, acks, wait_left;
        bit in_wait, ack_seen;
        build_model(num_core_lp, int'(a_ic), int'(a_dc), int'(a_cce));
        total = exp_q.size();
        accepted = 0; acks = 0; wait_left = 0; in_wait = 0; ack_seen = 0;
        a_start = 1'b1;
        @(negedge clk);
        a_start = 1'b0;
        for (int cyc = 0; cyc < 4000 && acks < total; cyc++) begin
            a_ack = 1'b0;
            a_ready = 1'b0;
            if (ack_seen) check("no_gap_after_ack", 64'(a_v), 64'(1));
            ack_seen = 0;
            if (a_v) begin
                if (accepted >= total) begin
                    check("extra_write", 64'(accepted), 64'(total - 1));
                    break;
                end
                check("payload", pack_a(), pack_exp(exp_q[accepted]));
                check("busy_send", 64'(a_busy), 64'(1));
                a_ready = ($urandom_range(0, 99) < ready_pct);
                if (noise && $urandom_range(0, 3) == 0) a_ack = 1'b1;
                if (a_ready) begin
                    accepted++;
                    in_wait = 1;
                    wait_left = $urandom_range(ack_min, ack_max);
                end
            end else if (in_wait) begin
                check("busy_wait", 64'(a_busy), 64'(1));
                if (wait_left == 0) begin
                    a_ack = 1'b1;
                    in_wait = 0;
                    acks++;
                    ack_seen = (acks < total);
                end else begin
                    wait_left--;
                end
            end else begin
                check("v_expected", 64'(a_v), 64'(1));
                break;
            end
            a_start = noise ? ($urandom_range(0, 4) == 0) : 1'b0;
            @(negedge clk);
        end
        a_start = 1'b0;
        a_ack = 1'b0;
        a_ready = 1'b0;
        check("write_count", 64'(accepted), 64'(total));
        check("ack_count", 64'(acks), 64'(total));
        check("done_after_last_ack", {a_done, a_busy, a_v, a_err}, 64'(4'b1000));
    endtask

    task automatic run_timeout();
        build_model(num_core_lp, int'(a_ic), int'(a_dc), int'(a_cce));
        a_start = 1'b1;
        @(negedge clk);
        a_start = 1'b0;
        check("to_v1", 64'(a_v), 64'(1));
        a_ready = 1'b1;
        @(negedge clk);
        a_ready = 1'b0;
        a_ack = 1'b1;
        @(negedge clk);
        a_ack = 1'b0;
        check("to_payload2", pack_a(), pack_exp(exp_q[1]));
        a_ready = 1'b1;
        @(negedge clk);
        a_ready = 1'b0;
        // Negedge k sits inside the k-th WAIT cycle after acceptance.
        for (int k = 1; k <= timeout_lp; k++) begin
            check("to_err", 64'(a_err), 64'(k == timeout_lp));
            check("to_busy", 64'(a_busy), 64'(k < timeout_lp));
            if (k < timeout_lp) @(negedge clk);
        end
        for (int k = 0; k < 6; k++) begin
            a_start = k[0];
            a_ack = ~k[0];
            a_ready = 1'b1;
            @(negedge clk);
            check("err_sticky", {a_err, a_v, a_busy, a_done}, 64'(4'b1000));
        end
        a_start = 1'b0;
        a_ack = 1'b0;
        a_ready = 1'b0;
    endtask

    task automatic run_reset_mid_wait();
        int accepted;
        accepted = 0;
        a_start = 1'b1;
        @(negedge clk);
        a_start = 1'b0;
        for (int cyc = 0; cyc < 100; cyc++) begin
            a_ack = 1'b0;
            a_ready = 1'b0;
            if (a_v) begin
                a_ready = 1'b1;
                accepted++;
            end else if (accepted == 7) begin
                break;
            end else begin
                a_ack = 1'b1;
            end
            @(negedge clk);
        end
        a_ack = 1'b0;
        a_ready = 1'b0;
        check("mid_wait_reached", {64'(accepted), 1'b0}, {64'(7), a_v});
        check("mid_wait_busy", 64'(a_busy), 64'(1));
        #2 reset = 1'b1;
        #1 check("async_reset_outputs", {a_v, a_busy, a_done, a_err, pack_a()}, 68'(0));
        @(negedge clk);
        reset = 1'b0;
        repeat (3) @(negedge clk);
        check("no_resume", {a_v, a_busy, a_done, a_err}, 64'(0));
    endtask

    typedef struct {
        logic [1:0]      ic;
        logic [1:0]      dc;
        logic            cce;
        logic [5:0][7:0] exp_data;
    } vec_t;

    vec_t vecs[4];

    task automatic run_b(input vec_t v);
        int idx, acks;
        idx = 0; acks = 0;
        b_ic = v.ic; b_dc = v.dc; b_cce = v.cce;
        b_start = 1'b1;
        @(negedge clk);
        b_start = 1'b0;
        for (int cyc = 0; cyc < 60 && acks < 6; cyc++) begin
            b_ack = 1'b0;
            if (b_v) begin
                if (idx >= 6) begin
                    check("b_extra_write", 64'(idx), 64'(5));
                    break;
                end
                check("b_data", 64'(b_data), 64'(v.exp_data[idx]));
                check("b_addr", {16'(b_core), b_addr}, 32'((idx < 5) ? idx : 0));
                idx++;
            end else if (idx > acks) begin
                b_ack = 1'b1;
                acks++;
            end
            @(negedge clk);
        end
        b_ack = 1'b0;
        check("b_write_count", 64'(idx), 64'(6));
        check("b_done", {b_done, b_busy, b_err}, 64'(3'b100));
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached, expected completion earlier");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = '{2'd2, 2'd1, 1'b1, {8'd0, 8'd1, 8'd1, 8'd2, 8'd0, 8'd1}};
        vecs[1] = '{2'd0, 2'd3, 1'b0, {8'd0, 8'd0, 8'd3, 8'd0, 8'd0, 8'd1}};
        vecs[2] = '{2'd3, 2'd2, 1'b1, {8'd0, 8'd1, 8'd2, 8'd3, 8'd0, 8'd1}};
        vecs[3] = '{2'd1, 2'd0, 1'b0, {8'd0, 8'd0, 8'd0, 8'd1, 8'd0, 8'd1}};

        reset = 1'b1;
        a_start = 1'b0; a_ready = 1'b0; a_ack = 1'b0; a_ic = '0; a_dc = '0; a_cce = 1'b0;
        b_start = 1'b0; b_ready = 1'b1; b_ack = 1'b0; b_ic = '0; b_dc = '0; b_cce = 1'b0;
        repeat (2) @(negedge clk);
        check("reset_a", {a_v, a_busy, a_done, a_err, pack_a()}, 68'(0));
        check("reset_b", {b_v, b_busy, b_done, b_err, 16'(b_core), b_addr, b_data}, 68'(0));
        reset = 1'b0;
        @(negedge clk);
        check("idle_a", {a_v, a_busy, a_done, a_err}, 64'(0));

        for (int i = 0; i < 4; i++) run_b(vecs[i]);

        a_ic = 2'd1; a_dc = 2'd2; a_cce = 1'b1;
        run_a(100, 0, 0, 1'b0);

        for (int r = 0; r < 6; r++) begin
            a_ic = 2'($urandom_range(0, 3));
            a_dc = 2'($urandom_range(0, 3));
            a_cce = 1'($urandom_range(0, 1));
            run_a($urandom_range(30, 90), 0, 5, r[0]);
        end

        a_ic = 2'd3; a_dc = 2'd0; a_cce = 1'b1;
        run_a(100, timeout_lp - 2, timeout_lp - 2, 1'b1);

        run_timeout();
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check("reset_clears_err", {a_err, a_v, a_busy, a_done}, 64'(0));
        run_a(60, 0, 3, 1'b0);

        run_reset_mid_wait();
        a_ic = 2'd2; a_dc = 2'd1; a_cce = 1'b0;
        run_a(70, 0, 4, 1'b1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
